// File: rtl/dac_multich.sv
// Multi-channel behavioural DAC: each channel has a shadow and an active register, updated per channel or all at once on ldac.
// Latency: a request accepted at edge k updates the outputs at edge k+SETTLE_CYC+1; while busy, writes are rejected and ldac is dropped.
module dac_multich #(
    parameter int  NBITS      = 12,
    parameter int  NCH        = 4,
    parameter real VREF       = 3.3,
    parameter int  SETTLE_CYC = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_en,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
    input  logic [NBITS-1:0]                       wr_data,
    input  logic                                   mode,
    input  logic                                   ldac,
    output logic                                   busy,
    output logic                                   upd_done,
    output logic                                   wr_err,
    output real                                    A_out [NCH]
);

    localparam int  CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int  CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam real FULL  = real'(64'd1 << NBITS);

    typedef enum logic [1:0] {IDLE, SETTLE, UPDATE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              all_flag, all_n;
    logic [CH_W-1:0]   pend_ch, pend_n;
    logic              shadow_we, do_upd, err_n, ch_ok;
    logic [NBITS-1:0]  shadow [NCH];
    logic [NBITS-1:0]  active [NCH];

    assign ch_ok = (32'(wr_ch) < NCH);
    assign busy  = (state != IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        all_n     = all_flag;
        pend_n    = pend_ch;
        shadow_we = 1'b0;
        do_upd    = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                err_n     = wr_en && !ch_ok;
                shadow_we = wr_en && ch_ok;
                // ldac wins over a direct write; the simultaneous write still reaches the shadow first
                if (ldac) begin
                    all_n   = 1'b1;
                    cnt_n   = CNT_W'(SETTLE_CYC - 1);
                    state_n = SETTLE;
                end else if (wr_en && ch_ok && !mode) begin
                    all_n   = 1'b0;
                    pend_n  = wr_ch;
                    cnt_n   = CNT_W'(SETTLE_CYC - 1);
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                err_n = wr_en;
                if (cnt == '0) state_n = UPDATE;
                else           cnt_n   = cnt - 1'b1;
            end
            UPDATE: begin
                err_n   = wr_en;
                do_upd  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            all_flag <= 1'b0;
            pend_ch  <= '0;
            upd_done <= 1'b0;
            wr_err   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            all_flag <= all_n;
            pend_ch  <= pend_n;
            upd_done <= do_upd;
            wr_err   <= err_n;
            if (shadow_we) shadow[wr_ch] <= wr_data;
            if (do_upd) begin
                for (int i = 0; i < NCH; i++) begin
                    if (all_flag || (32'(pend_ch) == i)) active[i] <= shadow[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) A_out[i] = VREF * real'(active[i]) / FULL;
    end

endmodule

// File: tb/tb_dac_multich.sv
// Randomized bench for dac_multich against a countdown-based reference model, plus directed corner cases and a small-parameter instance.
module tb_dac_multich;

    localparam int  NBITS = 12;
    localparam int  NCH   = 4;
    localparam real VREF  = 3.3;
    localparam int  SC    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, mode = 1'b0, ldac = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [11:0] wr_data = '0;
    logic        busy, upd_done, wr_err;
    real         A_out [NCH];

    logic        wr_en8 = 1'b0, mode8 = 1'b0, ldac8 = 1'b0;
    logic [1:0]  wr_ch8 = '0;
    logic [7:0]  wr_data8 = '0;
    logic        busy8, upd_done8, wr_err8;
    real         A8 [3];

    always #5 clk = ~clk;

    dac_multich #(.NBITS(NBITS), .NCH(NCH), .VREF(VREF), .SETTLE_CYC(SC)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .mode(mode), .ldac(ldac), .busy(busy), .upd_done(upd_done), .wr_err(wr_err),
        .A_out(A_out));

    dac_multich #(.NBITS(8), .NCH(3), .VREF(1.0), .SETTLE_CYC(2)) u_dut8 (
        .clk(clk), .rst(rst), .wr_en(wr_en8), .wr_ch(wr_ch8), .wr_data(wr_data8),
        .mode(mode8), .ldac(ldac8), .busy(busy8), .upd_done(upd_done8), .wr_err(wr_err8),
        .A_out(A8));

    int n_tests = 0;
    int n_fail  = 0;
    int n_upd   = 0;

    // Reference model: requests start a countdown of SC+1 edges; the transfer lands when it expires
    int m_shadow [NCH];
    int m_active [NCH];
    int m_rem = 0;
    int m_ch  = 0;
    bit m_all = 1'b0;
    bit exp_upd, exp_err;

    task automatic chk(input string tag, input real got, input real exp);
        n_tests++;
        if (((got - exp) > 1.0e-4) || ((exp - got) > 1.0e-4)) begin
            n_fail++;
            $display("FAIL %s: got %f expected %f", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        exp_upd = 1'b0;
        exp_err = 1'b0;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            m_rem = 0;
        end else if (m_rem > 0) begin
            exp_err = wr_en;
            m_rem--;
            if (m_rem == 0) begin
                exp_upd = 1'b1;
                for (int i = 0; i < NCH; i++)
                    if (m_all || i == m_ch) m_active[i] = m_shadow[i];
            end
        end else begin
            if (wr_en && int'(wr_ch) >= NCH) exp_err = 1'b1;
            if (wr_en && int'(wr_ch) < NCH) m_shadow[wr_ch] = int'(wr_data);
            if (ldac) begin
                m_all = 1'b1;
                m_rem = SC + 1;
            end else if (wr_en && int'(wr_ch) < NCH && !mode) begin
                m_all = 1'b0;
                m_ch  = int'(wr_ch);
                m_rem = SC + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (upd_done) n_upd++;
        chk("busy", real'(busy), real'(m_rem > 0));
        chk("upd_done", real'(upd_done), real'(exp_upd));
        chk("wr_err", real'(wr_err), real'(exp_err));
        for (int i = 0; i < NCH; i++)
            chk($sformatf("A_out[%0d]", i), A_out[i], VREF * real'(m_active[i]) / 4096.0);
    endtask

    task automatic drive(input bit we, input int ch, input int data, input bit md, input bit ld);
        wr_en   = we;
        wr_ch   = 2'(ch);
        wr_data = 12'(data);
        mode    = md;
        ldac    = ld;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic wait_upd8(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = upd_done8;
        end
        chk(tag, real'(seen), 1.0);
    endtask

    int upd_base;

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_aout1", A_out[1], 0.0);
        chk("reset_busy", real'(busy), 0.0);
        rst = 1'b0;

        // Reset during SETTLE aborts the transfer
        drive(1, 1, 2048, 0, 0); tick();
        idle(); tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        upd_base = n_upd;
        repeat (6) tick();
        chk("abort_no_upd", real'(n_upd - upd_base), 0.0);
        chk("abort_aout1", A_out[1], 0.0);

        // Direct mode full scale
        drive(1, 2, 4095, 0, 0); tick();
        idle();
        repeat (SC) tick();
        chk("direct_pre", A_out[2], 0.0);
        tick();
        chk("direct_upd", real'(upd_done), 1.0);
        chk("direct_full", A_out[2], 3.29919);
        chk("direct_other", A_out[0], 0.0);

        // Buffered writes, then one ldac; a second ldac while busy is dropped
        drive(1, 0, 1024, 1, 0); tick();
        drive(1, 1, 2048, 1, 0); tick();
        drive(1, 3, 3072, 1, 0); tick();
        idle(); tick();
        chk("buf_busy", real'(busy), 0.0);
        chk("buf_hold0", A_out[0], 0.0);
        upd_base = n_upd;
        drive(0, 0, 0, 1, 1); tick();
        idle(); tick();
        drive(0, 0, 0, 1, 1); tick();
        idle();
        repeat (4) tick();
        chk("buf_ch0", A_out[0], 0.825);
        chk("buf_ch1", A_out[1], 1.65);
        chk("buf_ch2", A_out[2], 3.29919);
        chk("buf_ch3", A_out[3], 2.475);
        chk("buf_single_upd", real'(n_upd - upd_base), 1.0);

        // Write with ldac in the same cycle joins the load-all; a write while busy is rejected
        drive(1, 0, 4095, 1, 1); tick();
        drive(1, 3, 100, 0, 0); tick();
        chk("busy_wr_err", real'(wr_err), 1.0);
        idle();
        repeat (SC) tick();
        chk("simul_ch0", A_out[0], 3.29919);
        drive(0, 0, 0, 0, 1); tick();
        idle();
        repeat (SC + 1) tick();
        chk("shadow_kept", A_out[3], 2.475);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(99) == 0);
            drive(($urandom_range(9) < 4), $urandom_range(3), $urandom_range(4095),
                  $urandom_range(1), ($urandom_range(9) == 0));
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (SC + 2) tick();

        // Small parameter set: 8 bits, 3 channels, VREF 1.0
        wr_en8 = 1'b1; wr_ch8 = 2'd0; wr_data8 = 8'd128; mode8 = 1'b0;
        @(posedge clk); #1;
        wr_en8 = 1'b0;
        wait_upd8("p8_upd128");
        chk("p8_code128", A8[0], 0.5);
        wr_en8 = 1'b1; wr_ch8 = 2'd2; wr_data8 = 8'd255;
        @(posedge clk); #1;
        wr_en8 = 1'b0;
        wait_upd8("p8_upd255");
        chk("p8_code255", A8[2], 0.99609);
        chk("p8_other", A8[1], 0.0);
        wr_en8 = 1'b1; wr_ch8 = 2'd3; wr_data8 = 8'd77;
        @(posedge clk); #1;
        wr_en8 = 1'b0;
        chk("p8_badch_err", real'(wr_err8), 1.0);
        chk("p8_badch_busy", real'(busy8), 0.0);
        @(posedge clk); #1;
        chk("p8_err_pulse", real'(wr_err8), 0.0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
